// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router synchroniser.
package router_pkg;

  localparam int unsigned DEF_NUM_PORTS = 3;
  localparam int unsigned DEF_TIMEOUT   = 30;
  localparam int unsigned DEF_CNT_W     = 5;
  localparam int unsigned MAX_PORTS     = 8;

  // Address field width needed to name n channels (at least one bit).
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of addr over n channels; out-of-range gives all zeros.
  function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned addr,
                                                  input int unsigned n);
    logic [MAX_PORTS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      oh[i] = (i == addr) && (i < n);
    end
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel unread-data watchdog that raises soft_reset after TIMEOUT idle cycles.
// ROUTER_SYNC_SOFT_RST_HOLD_EN: hold soft_reset until the FIFO drains empty.
module router_sync_timer #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  input  logic empty,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             idle;

  assign idle = vld & ~rd;

`ifdef ROUTER_SYNC_SOFT_RST_HOLD_EN
  // While the reset is held the counter parks at zero; it releases once empty is seen.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      cnt        <= '0;
      soft_reset <= ~empty;
    end else if (idle) begin
      if (cnt == CNT_LAST) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_empty;
  assign unused_empty = empty;

  // One-cycle pulse; counting resumes during the pulse if the channel stays idle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      if (idle) begin
        if (cnt == CNT_LAST) begin
          cnt        <= '0;
          soft_reset <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches header address, steers FIFO writes, reports status.
// ROUTER_SYNC_SOFT_RST_HOLD_EN: held soft_reset that also blocks writes to that FIFO.
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W    = addr_w(DEF_NUM_PORTS),
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_addr,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] write_en,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  localparam logic [ADDR_W:0] PORTS_LIM = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_vld;
  logic                 addr_in_range;
  logic [NUM_PORTS-1:0] sel_oh;

  assign addr_in_range = ({1'b0, data_in} < PORTS_LIM);

  // Header address latch; held until the next header.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q   <= '0;
      addr_vld <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (detect_addr) begin
        addr_q   <= data_in;
        addr_vld <= addr_in_range;
        addr_err <= ~addr_in_range;
      end
    end
  end

  assign sel_oh = NUM_PORTS'(onehot(32'(addr_q), NUM_PORTS));

  // Steering and status of the addressed FIFO; unselected full flags are ignored.
  always_comb begin
    write_en  = '0;
    fifo_full = 1'b0;
    if (addr_vld) begin
      fifo_full = |(full & sel_oh);
      if (write_enb_reg) begin
        write_en = sel_oh;
      end
    end
`ifdef ROUTER_SYNC_SOFT_RST_HOLD_EN
    write_en = write_en & ~soft_reset;
`endif
  end

  assign vld_out = ~empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_out[i]),
      .rd        (read_enb[i]),
      .empty     (empty[i]),
      .soft_reset(soft_reset[i])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: stimulus queues expected outputs, monitor checks them.
module tb_router_sync_n;

`ifdef ROUTER_SYNC_SOFT_RST_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Output vector layout: {addr_err, soft_reset[2:0], write_en[2:0], fifo_full, vld_out[2:0]}
  localparam logic [10:0] M_AE  = 11'h400;
  localparam logic [10:0] M_SR  = 11'h380;
  localparam logic [10:0] M_WE  = 11'h070;
  localparam logic [10:0] M_FF  = 11'h008;
  localparam logic [10:0] M_VO  = 11'h007;
  localparam logic [10:0] M_ALL = 11'h7FF;

  logic       clock;
  logic       resetn;
  logic       detect_addr;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] vld_out;
  logic       fifo_full;
  logic [2:0] write_en;
  logic [2:0] soft_reset;
  logic       addr_err;

  typedef struct {
    string       nm;
    logic [10:0] m;
    logic [10:0] e;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [10:0] got;
  int          checks   = 0;
  int          failures = 0;

  router_sync_n #(
    .NUM_PORTS(3),
    .ADDR_W   (2),
    .TIMEOUT  (30),
    .CNT_W    (5)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_addr  (detect_addr),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb     (read_enb),
    .full         (full),
    .empty        (empty),
    .vld_out      (vld_out),
    .fifo_full    (fifo_full),
    .write_en     (write_en),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] pk(input logic ae, input logic [2:0] sr,
                                     input logic [2:0] we, input logic ff,
                                     input logic [2:0] vo);
    return {ae, sr, we, ff, vo};
  endfunction

  task automatic expect_now(input string nm, input logic [10:0] m, input logic [10:0] e);
    exp_t x;
    x.nm = nm;
    x.m  = m;
    x.e  = e;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs sampled mid-cycle, compared against the oldest queued expectation.
  always @(negedge clock) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      got = {addr_err, soft_reset, write_en, fifo_full, vld_out};
      checks++;
      if ((got & cur.m) !== (cur.e & cur.m)) begin
        failures++;
        $display("FAIL %s: got=%b exp=%b mask=%b", cur.nm, got, cur.e, cur.m);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [2:0] sr_exp;
    resetn        = 1'b0;
    detect_addr   = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b0;
    read_enb      = 3'b000;
    full          = 3'b000;
    empty         = 3'b111;

    tick();
    write_enb_reg = 1'b1;
    full          = 3'b111;
    expect_now("reset", M_ALL, pk(0, 3'b000, 3'b000, 0, 3'b000));
    tick();

    // Address capture and steering
    resetn = 1'b1; write_enb_reg = 1'b0; full = 3'b000;
    detect_addr = 1'b1; data_in = 2'd2;
    expect_now("pre_detect", M_ALL, pk(0, 3'b000, 3'b000, 0, 3'b000));
    tick();
    detect_addr = 1'b0; write_enb_reg = 1'b1; full = 3'b001;
    expect_now("we_addr2", M_ALL, pk(0, 3'b000, 3'b100, 0, 3'b000));
    tick();
    full = 3'b100;
    expect_now("ff_sel", M_ALL, pk(0, 3'b000, 3'b100, 1, 3'b000));
    tick();
    full = 3'b011; write_enb_reg = 1'b0;
    expect_now("ff_unsel", M_ALL, pk(0, 3'b000, 3'b000, 0, 3'b000));
    tick();
    detect_addr = 1'b1; data_in = 2'd0; write_enb_reg = 1'b1; full = 3'b000;
    expect_now("same_cycle_old", M_ALL, pk(0, 3'b000, 3'b100, 0, 3'b000));
    tick();
    detect_addr = 1'b0;
    expect_now("same_cycle_new", M_ALL, pk(0, 3'b000, 3'b001, 0, 3'b000));
    tick();

    // Out-of-range address
    detect_addr = 1'b1; data_in = 2'd3;
    expect_now("pre_bad", M_ALL, pk(0, 3'b000, 3'b001, 0, 3'b000));
    tick();
    detect_addr = 1'b0; full = 3'b111;
    expect_now("addr_err_hi", M_ALL, pk(1, 3'b000, 3'b000, 0, 3'b000));
    tick();
    expect_now("addr_err_lo", M_ALL, pk(0, 3'b000, 3'b000, 0, 3'b000));
    tick();
    detect_addr = 1'b1; data_in = 2'd1; write_enb_reg = 1'b0; full = 3'b000;
    expect_now("recover_pre", M_ALL, pk(0, 3'b000, 3'b000, 0, 3'b000));
    tick();
    detect_addr = 1'b0; write_enb_reg = 1'b1; full = 3'b010;
    empty = 3'b101; read_enb = 3'b010;
    expect_now("recover", M_ALL, pk(0, 3'b000, 3'b010, 1, 3'b010));
    tick();

    // Channel 1 timeout with repeat
    write_enb_reg = 1'b0; full = 3'b000; read_enb = 3'b000;
    for (int i = 1; i <= 62; i++) begin
      sr_exp = (HOLD ? (i >= 31) : (i == 31 || i == 61)) ? 3'b010 : 3'b000;
      expect_now($sformatf("idle_c%0d", i), M_SR | M_WE | M_VO,
                 pk(0, sr_exp, 3'b000, 0, 3'b010));
      tick();
    end
    empty = 3'b111;
    tick();
    tick();

    // Read exactly when the counter sits at TIMEOUT-1, then a full idle run
    empty = 3'b101;
    for (int i = 1; i <= 62; i++) begin
      read_enb = (i == 30) ? 3'b010 : 3'b000;
      sr_exp   = ((i == 61) || (HOLD && i > 61)) ? 3'b010 : 3'b000;
      expect_now($sformatf("rd_c%0d", i), M_SR | M_VO, pk(0, sr_exp, 3'b000, 0, 3'b010));
      tick();
    end
    read_enb = 3'b000; empty = 3'b111;
    tick();
    tick();

    // Mid-count reset on channel 0, then channels 0 and 2 time out together
    empty = 3'b110;
    for (int i = 1; i <= 16; i++) begin
      resetn = (i == 16) ? 1'b0 : 1'b1;
      expect_now($sformatf("prerst_c%0d", i), M_SR | M_VO, pk(0, 3'b000, 3'b000, 0, 3'b001));
      tick();
    end
    resetn = 1'b1; empty = 3'b010; write_enb_reg = 1'b1; full = 3'b111;
    for (int r = 1; r <= 32; r++) begin
      sr_exp = ((r == 31) || (HOLD && r > 31)) ? 3'b101 : 3'b000;
      expect_now($sformatf("postrst_c%0d", r), M_ALL, pk(0, sr_exp, 3'b000, 0, 3'b101));
      tick();
    end
    empty = 3'b111; write_enb_reg = 1'b0; full = 3'b000;
    tick();
    tick();

`ifdef ROUTER_SYNC_SOFT_RST_HOLD_EN
    // Held reset on channel 0 blocks writes until the FIFO reports empty
    detect_addr = 1'b1; data_in = 2'd0;
    tick();
    detect_addr = 1'b0; write_enb_reg = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      empty  = (i >= 37) ? 3'b111 : 3'b110;
      sr_exp = (i >= 31 && i <= 37) ? 3'b001 : 3'b000;
      expect_now($sformatf("hold_c%0d", i), M_SR | M_WE | M_VO,
                 pk(0, sr_exp, (sr_exp[0] ? 3'b000 : 3'b001), 0,
                    ((i >= 37) ? 3'b000 : 3'b001)));
      tick();
    end
    write_enb_reg = 1'b0;
`endif

    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
